trigger_sequencer: RTL and testbench

//  Parametrised multi-stage trigger sequencer; successor to the single-source trigger mux.

---
 rtl/trigger_sequencer.sv | 137 +++++++++++++
 tb/tb_trigger_sequencer.sv | 358 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/trigger_sequencer.sv
// Multi-stage trigger sequencer: ordered source edges, each later stage inside a cycle window.
// Emits a one-cycle O_trigger on a full match and a one-cycle O_timeout on window expiry.
module trigger_sequencer #(
  parameter int unsigned NUM_SRC    = 8,
  parameter int unsigned NUM_STAGES = 4,
  parameter int unsigned CNT_W      = 16,
  localparam int unsigned SELW      = $clog2(NUM_SRC),
  localparam int unsigned STW       = $clog2(NUM_STAGES)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        I_arm,
  input  logic [NUM_SRC-1:0]          I_src,
  input  logic [NUM_STAGES*SELW-1:0]  I_stage_sel,
  input  logic [STW:0]                I_num_stages,
  input  logic [NUM_STAGES*CNT_W-1:0] I_window_min,
  input  logic [NUM_STAGES*CNT_W-1:0] I_window_max,
  output logic                        O_trigger,
  output logic                        O_timeout,
  output logic [STW-1:0]              O_stage,
  output logic                        O_busy
);

  typedef enum logic [1:0] {IDLE, WAIT, FIRE} state_t;

  state_t             state_q, state_d;
  logic [STW-1:0]     stage_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [NUM_SRC-1:0] src_prev;
  logic               trig_d, tmo_d;

  logic [NUM_SRC-1:0] rise;
  logic [SELW-1:0]    cur_sel;
  logic [CNT_W-1:0]   cur_min, cur_max;
  logic [STW-1:0]     last_stage;
  logic               cur_rise, in_window, accept, expire;

  assign rise = I_src & ~src_prev;

  // Per-stage configuration of the stage currently being waited on
  always_comb begin
    cur_sel  = I_stage_sel[SELW*32'(O_stage) +: SELW];
    cur_min  = I_window_min[CNT_W*32'(O_stage) +: CNT_W];
    cur_max  = I_window_max[CNT_W*32'(O_stage) +: CNT_W];
    cur_rise = rise[cur_sel];
  end

  // Clamp the requested stage count to 1..NUM_STAGES
  always_comb begin
    if (I_num_stages == '0) begin
      last_stage = '0;
    end else if (32'(I_num_stages) >= NUM_STAGES) begin
      last_stage = STW'(NUM_STAGES - 1);
    end else begin
      last_stage = STW'(I_num_stages - 1'b1);
    end
  end

  // Stage 0 has no window; a rise at the max boundary beats the timeout
  always_comb begin
    in_window = (cnt_q >= cur_min) && ((cur_max == '0) || (cnt_q <= cur_max));
    accept    = cur_rise && ((O_stage == '0) || in_window);
    expire    = (O_stage != '0) && (cur_max != '0) && (cnt_q == cur_max);
  end

  always_comb begin
    state_d = state_q;
    stage_d = O_stage;
    cnt_d   = cnt_q;
    trig_d  = 1'b0;
    tmo_d   = 1'b0;
    if (!I_arm) begin
      state_d = IDLE;
      stage_d = '0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = WAIT;
          stage_d = '0;
          cnt_d   = '0;
        end
        WAIT: begin
          if (accept) begin
            cnt_d = '0;
            if (O_stage >= last_stage) begin
              state_d = FIRE;
              stage_d = '0;
            end else begin
              stage_d = O_stage + STW'(1);
            end
          end else if (expire) begin
            stage_d = '0;
            cnt_d   = '0;
            tmo_d   = 1'b1;
          end else if ((O_stage != '0) && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        FIRE: begin
          // Rises sampled here are dropped; sequence restarts at stage 0
          trig_d  = 1'b1;
          state_d = WAIT;
          stage_d = '0;
          cnt_d   = '0;
        end
        default: begin
          state_d = IDLE;
          stage_d = '0;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // src_prev resets high so a source already asserted out of reset is not an edge
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      O_stage   <= '0;
      cnt_q     <= '0;
      src_prev  <= '1;
      O_trigger <= 1'b0;
      O_timeout <= 1'b0;
      O_busy    <= 1'b0;
    end else begin
      state_q   <= state_d;
      O_stage   <= stage_d;
      cnt_q     <= cnt_d;
      src_prev  <= I_src;
      O_trigger <= trig_d;
      O_timeout <= tmo_d;
      O_busy    <= (stage_d != '0);
    end
  end

endmodule

// File: tb/tb_trigger_sequencer.sv
// Bench for trigger_sequencer: directed scenarios plus randomized runs against
// a time-stamp based reference model of the sequencing rules.
module tb_trigger_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        I_arm;
  logic [7:0]  I_src;
  logic [11:0] I_stage_sel;
  logic [2:0]  I_num_stages;
  logic [63:0] I_window_min, I_window_max;
  logic        O_trigger, O_timeout, O_busy;
  logic [1:0]  O_stage;

  int errors = 0;
  int checks = 0;

  trigger_sequencer dut (
    .clk(clk), .reset(reset), .I_arm(I_arm), .I_src(I_src),
    .I_stage_sel(I_stage_sel), .I_num_stages(I_num_stages),
    .I_window_min(I_window_min), .I_window_max(I_window_max),
    .O_trigger(O_trigger), .O_timeout(O_timeout), .O_stage(O_stage), .O_busy(O_busy)
  );

  always #5 clk = ~clk;

  // Reference model: phase 0=idle 1=waiting 2=match pending; windows from accept timestamps
  logic [7:0] m_prev;
  int         m_phase, m_stage;
  longint     m_now = 0, m_t_acc = 0;
  logic       e_trig, e_tmo;
  int         e_stage;

  task automatic m_reset();
    m_prev = '1; m_phase = 0; m_stage = 0;
    e_trig = 1'b0; e_tmo = 1'b0; e_stage = 0;
  endtask

  task automatic m_edge();
    logic [7:0] rise;
    int n, sel, mn, mx;
    longint c;
    bit acc;
    rise = I_src & ~m_prev;
    m_prev = I_src;
    m_now++;
    e_trig = 1'b0; e_tmo = 1'b0;
    n = (I_num_stages == 0) ? 1 : ((I_num_stages > 4) ? 4 : int'(I_num_stages));
    if (!I_arm) begin
      m_phase = 0; m_stage = 0;
    end else if (m_phase == 0) begin
      m_phase = 1; m_stage = 0;
    end else if (m_phase == 2) begin
      e_trig = 1'b1; m_phase = 1; m_stage = 0;
    end else begin
      sel = int'(I_stage_sel[m_stage*3 +: 3]);
      acc = rise[sel];
      if (m_stage > 0) begin
        mn = int'(I_window_min[m_stage*16 +: 16]);
        mx = int'(I_window_max[m_stage*16 +: 16]);
        c = m_now - m_t_acc - 1;
        if (c > 65535) c = 65535;
        acc = acc && (c >= mn) && (mx == 0 || c <= mx);
        if (!acc && mx != 0 && c == mx) begin
          e_tmo = 1'b1; m_stage = 0;
        end
      end
      if (acc) begin
        m_t_acc = m_now;
        if (m_stage >= n - 1) begin m_phase = 2; m_stage = 0; end
        else m_stage++;
      end
    end
    e_stage = m_stage;
  endtask

  function automatic logic [4:0] got_vec();
    return {O_trigger, O_timeout, O_stage, O_busy};
  endfunction

  function automatic logic [4:0] exp_vec();
    return {e_trig, e_tmo, 2'(e_stage), (e_stage != 0)};
  endfunction

  task automatic tick();
    @(posedge clk);
    if (!reset) m_edge();
    #1;
  endtask

  task automatic disarm();
    I_arm = 1'b0; I_src = '0;
    tick(); tick();
  endtask

  task automatic arm();
    I_arm = 1'b1;
    tick(); tick();
  endtask

  task automatic test_reset();
    int trig_cnt = 0;
    reset = 1'b1; I_arm = 1'b0; I_src = '1;
    I_stage_sel = '0; I_num_stages = 3'd1; I_window_min = '0; I_window_max = '0;
    m_reset();
    tick(); tick();
    checks++;
    if (got_vec() !== 5'b0) begin
      errors++; $display("FAIL reset_state: got %b want 00000", got_vec());
    end
    reset = 1'b0; I_arm = 1'b1;
    for (int t = 0; t < 6; t++) begin
      tick();
      checks++;
      if (got_vec() !== exp_vec()) begin
        errors++; $display("FAIL reset_src_high t=%0d: got %b want %b", t, got_vec(), exp_vec());
      end
      if (O_trigger) trig_cnt++;
    end
    checks++;
    if (trig_cnt !== 0) begin
      errors++; $display("FAIL reset_no_fire: got %0d triggers want 0", trig_cnt);
    end
  endtask

  task automatic test_single();
    int trig_cnt = 0, trig_t = -1;
    bit busy_seen = 0;
    disarm();
    I_num_stages = 3'd1; I_stage_sel = 12'd2;
    arm();
    for (int t = 0; t < 6; t++) begin
      I_src = '0; I_src[2] = (t == 0);
      tick();
      checks++;
      if (got_vec() !== exp_vec()) begin
        errors++; $display("FAIL single t=%0d: got %b want %b", t, got_vec(), exp_vec());
      end
      if (O_trigger) begin trig_cnt++; trig_t = t; end
      if (O_busy) busy_seen = 1;
    end
    checks++;
    if (trig_cnt !== 1 || trig_t !== 1 || busy_seen !== 1'b0) begin
      errors++; $display("FAIL single_pulse: got cnt=%0d t=%0d busy=%0d want 1 1 0", trig_cnt, trig_t, busy_seen);
    end
  endtask

  task automatic test_three_stage();
    int trig_cnt = 0, trig_t = -1;
    int st[3];
    disarm();
    I_num_stages = 3'd3;
    I_stage_sel  = {3'd0, 3'd2, 3'd1, 3'd0};
    I_window_min = {16'd0, 16'd5, 16'd5, 16'd0};
    I_window_max = {16'd0, 16'd10, 16'd10, 16'd0};
    arm();
    for (int t = 0; t < 22; t++) begin
      I_src = '0;
      I_src[0] = (t == 0); I_src[1] = (t == 7); I_src[2] = (t == 15);
      tick();
      checks++;
      if (got_vec() !== exp_vec()) begin
        errors++; $display("FAIL three_stage t=%0d: got %b want %b", t, got_vec(), exp_vec());
      end
      if (O_trigger) begin trig_cnt++; trig_t = t; end
      if (t == 3)  st[0] = int'(O_stage);
      if (t == 10) st[1] = int'(O_stage);
      if (t == 18) st[2] = int'(O_stage);
    end
    checks++;
    if (trig_cnt !== 1 || trig_t !== 16) begin
      errors++; $display("FAIL three_stage_trigger: got cnt=%0d t=%0d want 1 16", trig_cnt, trig_t);
    end
    checks++;
    if (st[0] !== 1 || st[1] !== 2 || st[2] !== 0) begin
      errors++; $display("FAIL three_stage_progress: got %0d %0d %0d want 1 2 0", st[0], st[1], st[2]);
    end
  endtask

  task automatic test_timeout();
    int tmo_cnt = 0, tmo_t = -1, trig_cnt = 0;
    disarm();
    I_num_stages = 3'd2;
    I_stage_sel  = {3'd0, 3'd0, 3'd1, 3'd0};
    I_window_min = {16'd0, 16'd0, 16'd5, 16'd0};
    I_window_max = {16'd0, 16'd0, 16'd10, 16'd0};
    arm();
    for (int t = 0; t < 17; t++) begin
      I_src = '0; I_src[0] = (t == 0); I_src[1] = (t == 4);
      tick();
      checks++;
      if (got_vec() !== exp_vec()) begin
        errors++; $display("FAIL timeout t=%0d: got %b want %b", t, got_vec(), exp_vec());
      end
      if (O_timeout) begin tmo_cnt++; tmo_t = t; end
      if (O_trigger) trig_cnt++;
    end
    checks++;
    if (tmo_cnt !== 1 || tmo_t !== 11 || trig_cnt !== 0 || O_stage !== 2'd0) begin
      errors++; $display("FAIL timeout_once: got cnt=%0d t=%0d trig=%0d stage=%0d want 1 11 0 0",
                         tmo_cnt, tmo_t, trig_cnt, O_stage);
    end
  endtask

  task automatic test_boundary();
    int tmo_cnt, trig_cnt, trig_t, d;
    for (int r = 0; r < 3; r++) begin
      d = (r == 0) ? 6 : ((r == 1) ? 11 : 70001);
      tmo_cnt = 0; trig_cnt = 0; trig_t = -1;
      disarm();
      I_num_stages = 3'd2;
      I_stage_sel  = {3'd0, 3'd0, 3'd1, 3'd0};
      I_window_min = {16'd0, 16'd0, 16'd5, 16'd0};
      I_window_max = {16'd0, 16'd0, (r == 2) ? 16'd0 : 16'd10, 16'd0};
      arm();
      for (int t = 0; t < d + 4; t++) begin
        I_src = '0; I_src[0] = (t == 0); I_src[1] = (t == d);
        tick();
        checks++;
        if (got_vec() !== exp_vec()) begin
          errors++; $display("FAIL boundary r=%0d t=%0d: got %b want %b", r, t, got_vec(), exp_vec());
        end
        if (O_timeout) tmo_cnt++;
        if (O_trigger) begin trig_cnt++; trig_t = t; end
      end
      checks++;
      if (tmo_cnt !== 0 || trig_cnt !== 1 || trig_t !== d + 1) begin
        errors++; $display("FAIL boundary_accept r=%0d: got tmo=%0d trig=%0d t=%0d want 0 1 %0d",
                           r, tmo_cnt, trig_cnt, trig_t, d + 1);
      end
    end
  endtask

  task automatic test_same_source();
    int trig_cnt_early = 0, trig_t = -1, st_hold = -1;
    disarm();
    I_num_stages = 3'd2;
    I_stage_sel  = {3'd0, 3'd0, 3'd4, 3'd4};
    I_window_min = '0;
    I_window_max = '0;
    arm();
    for (int t = 0; t < 31; t++) begin
      I_src = '0; I_src[4] = (t < 20) || (t >= 25);
      tick();
      checks++;
      if (got_vec() !== exp_vec()) begin
        errors++; $display("FAIL same_source t=%0d: got %b want %b", t, got_vec(), exp_vec());
      end
      if (O_trigger && t < 25) trig_cnt_early++;
      if (O_trigger) trig_t = t;
      if (t == 10) st_hold = int'(O_stage);
    end
    checks++;
    if (trig_cnt_early !== 0 || st_hold !== 1 || trig_t !== 26) begin
      errors++; $display("FAIL same_source_one_edge: got early=%0d stage=%0d t=%0d want 0 1 26",
                         trig_cnt_early, st_hold, trig_t);
    end
  endtask

  task automatic test_disarm_and_reset();
    int pulses = 0, st9 = -1, trig_cnt = 0;
    disarm();
    I_num_stages = 3'd3;
    I_stage_sel  = {3'd0, 3'd2, 3'd1, 3'd0};
    I_window_min = {16'd0, 16'd5, 16'd5, 16'd0};
    I_window_max = {16'd0, 16'd10, 16'd10, 16'd0};
    arm();
    for (int t = 0; t < 15; t++) begin
      I_src = '0; I_src[0] = (t == 0); I_src[1] = (t == 7); I_src[2] = (t == 12);
      I_arm = (t < 10);
      tick();
      checks++;
      if (got_vec() !== exp_vec()) begin
        errors++; $display("FAIL disarm t=%0d: got %b want %b", t, got_vec(), exp_vec());
      end
      if (O_trigger || O_timeout) pulses++;
      if (t == 9) st9 = int'(O_stage);
    end
    checks++;
    if (st9 !== 2 || pulses !== 0 || O_stage !== 2'd0 || O_busy !== 1'b0) begin
      errors++; $display("FAIL disarm_idle: got st9=%0d pulses=%0d stage=%0d busy=%0d want 2 0 0 0",
                         st9, pulses, O_stage, O_busy);
    end
    // Mid-sequence async reset, then a source held high out of reset
    arm();
    I_src = 8'h01; tick();
    I_src = '0; tick(); tick();
    checks++;
    if (O_stage !== 2'd1) begin
      errors++; $display("FAIL reset_pre_stage: got %0d want 1", O_stage);
    end
    #2 reset = 1'b1;
    #1;
    m_reset();
    checks++;
    if (got_vec() !== 5'b0) begin
      errors++; $display("FAIL reset_async: got %b want 00000", got_vec());
    end
    I_src = '1;
    tick(); tick();
    reset = 1'b0;
    for (int t = 0; t < 8; t++) begin
      I_src = (t < 5) ? 8'hFF : 8'h00;
      tick();
      checks++;
      if (got_vec() !== exp_vec()) begin
        errors++; $display("FAIL reset_recover t=%0d: got %b want %b", t, got_vec(), exp_vec());
      end
      if (O_trigger) trig_cnt++;
    end
    checks++;
    if (trig_cnt !== 0) begin
      errors++; $display("FAIL reset_no_fire_held: got %0d triggers want 0", trig_cnt);
    end
  endtask

  task automatic test_random();
    int mn;
    for (int r = 0; r < 40; r++) begin
      disarm();
      I_num_stages = 3'($urandom_range(0, 7));
      I_stage_sel  = 12'($urandom);
      for (int k = 0; k < 4; k++) begin
        mn = $urandom_range(0, 4);
        I_window_min[k*16 +: 16] = 16'(mn);
        I_window_max[k*16 +: 16] = ($urandom_range(0, 3) == 0) ? 16'd0 : 16'(mn + $urandom_range(0, 6));
      end
      arm();
      for (int t = 0; t < 80; t++) begin
        for (int b = 0; b < 8; b++) I_src[b] = ($urandom_range(0, 5) == 0);
        I_arm = ($urandom_range(0, 60) != 0);
        tick();
        checks++;
        if (got_vec() !== exp_vec()) begin
          errors++; $display("FAIL random r=%0d t=%0d: got %b want %b", r, t, got_vec(), exp_vec());
        end
        checks++;
        if (O_trigger && O_timeout) begin
          errors++; $display("FAIL random_exclusive r=%0d t=%0d: got both pulses want at most one", r, t);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_three_stage();
    test_timeout();
    test_boundary();
    test_same_source();
    test_disarm_and_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
